// File: rtl/sha256_host_ctrl_pkg.sv
// rtl/sha256_host_ctrl_pkg.sv - sha256_core address map, status bits and host controller state encoding
//
// Contents:
//   CORE_* address constants  register map of sha256_core as seen over its byte bus
//   STAT_* bit indices        fields of the core status register
//   LEN_SINGLE / LEN_DOUBLE   message lengths for the two command modes
//   state_t                   host controller FSM states
//   status_cmd()              builds the status-register write that launches a hash
package sha256_host_ctrl_pkg;

    localparam logic [6:0] CORE_MSG_BASE       = 7'h00;
    localparam logic [6:0] CORE_END_W_MEM_ADDR = 7'h4F;
    localparam logic [6:0] CORE_STATUS_ADDR    = 7'h51;
    localparam logic [6:0] CORE_DIGEST_BASE    = 7'h58;
    localparam logic [6:0] CORE_DIGEST_END     = 7'h77;

    localparam int STAT_START        = 0;
    localparam int STAT_BITCOIN_MODE = 1;
    localparam int STAT_NONCE_SWEEP  = 2;
    localparam int STAT_COMPLETED    = 3;

    localparam logic [6:0] LEN_SINGLE = 7'd64;
    localparam logic [6:0] LEN_DOUBLE = 7'd80;

    localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_ARM   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RD    = 3'd5,
        ST_OUT   = 3'd6
    } state_t;

    // Start bit set, nonce sweep never requested from this controller.
    function automatic logic [7:0] status_cmd(input logic bitcoin);
        logic [7:0] b;
        b                    = 8'h00;
        b[STAT_START]        = 1'b1;
        b[STAT_BITCOIN_MODE] = bitcoin;
        b[STAT_NONCE_SWEEP]  = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/sha256_host_ctrl.sv
// rtl/sha256_host_ctrl.sv - streams a message into sha256_core, runs a hash and streams the digest out
//
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_cmd_valid, i_cmd_mode            command request (0 = single 64-byte block, 1 = Bitcoin double hash of 80-byte header)
//   o_cmd_ready                        high only while idle
//   i_s_data, i_s_valid, o_s_ready     message byte stream in
//   o_core_addr, o_core_data,
//   o_core_we, i_core_data, i_core_irq byte-wide register bus to sha256_core plus its completion flag
//   o_d_data, o_d_valid, i_d_ready,
//   o_d_last                           32-byte digest stream out, MSB first
//   o_busy                             high whenever not idle
//   o_err                              sticky completion timeout, cleared by the next command
module sha256_host_ctrl
    import sha256_host_ctrl_pkg::*;
#(
    parameter logic [6:0]  MSG_BASE    = CORE_MSG_BASE,
    parameter logic [6:0]  STATUS_ADDR = CORE_STATUS_ADDR,
    parameter logic [6:0]  DIGEST_BASE = CORE_DIGEST_BASE,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_mode,
    output logic       o_cmd_ready,
    input  logic [7:0] i_s_data,
    input  logic       i_s_valid,
    output logic       o_s_ready,
    output logic [6:0] o_core_addr,
    output logic [7:0] o_core_data,
    output logic       o_core_we,
    input  logic [7:0] i_core_data,
    input  logic       i_core_irq,
    output logic [7:0] o_d_data,
    output logic       o_d_valid,
    input  logic       i_d_ready,
    output logic       o_d_last,
    output logic       o_busy,
    output logic       o_err
);

    state_t      state;
    state_t      state_nx;

    logic        mode;
    logic [6:0]  len;
    logic [6:0]  k;
    logic [4:0]  j;
    logic [15:0] tmo;
    logic [7:0]  d_data;
    logic        d_valid;
    logic        err;

    // tmo holds cycles elapsed since START (START itself counts as one);
    // the wait expires on the cycle that would bring it to TIMEOUT_CYC.
    logic [16:0] tmo_inc;
    logic        tmo_hit;
    logic        last_byte;
    logic [4:0]  digest_off;

    assign tmo_inc    = {1'b0, tmo} + 17'd1;
    assign tmo_hit    = tmo_inc >= {1'b0, TIMEOUT_CYC};
    assign last_byte  = i_s_valid && (k == (len - 7'd1));
    // Digest lives little-endian in the core; walk it top-down for SHA byte order.
    assign digest_off = 5'd31 - j;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        o_cmd_ready = 1'b0;
        o_s_ready   = 1'b0;
        o_core_we   = 1'b0;
        o_core_addr = STATUS_ADDR;
        o_core_data = 8'h00;
        case (state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // First stream byte lands at the top of the window.
                o_s_ready   = 1'b1;
                o_core_we   = i_s_valid;
                o_core_addr = MSG_BASE + (len - 7'd1 - k);
                o_core_data = i_s_data;
                if (last_byte) begin
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                o_core_we   = 1'b1;
                o_core_data = status_cmd(mode);
                state_nx    = ST_ARM;
            end
            ST_ARM: begin
                // The completed flag from a previous run is still up until the
                // core acknowledges start; wait for it to drop first.
                if (tmo_hit) begin
                    state_nx = ST_IDLE;
                end else if (!i_core_irq) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tmo_hit) begin
                    state_nx = ST_IDLE;
                end else if (i_core_irq) begin
                    state_nx = ST_RD;
                end
            end
            ST_RD: begin
                o_core_addr = DIGEST_BASE + {2'b00, digest_off};
                state_nx    = ST_OUT;
            end
            ST_OUT: begin
                o_core_addr = DIGEST_BASE + {2'b00, digest_off};
                if (i_d_ready) begin
                    state_nx = (j == 5'd31) ? ST_IDLE : ST_RD;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode    <= 1'b0;
            len     <= 7'd0;
            k       <= 7'd0;
            j       <= 5'd0;
            tmo     <= 16'd0;
            d_data  <= 8'h00;
            d_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        mode <= i_cmd_mode;
                        len  <= i_cmd_mode ? LEN_DOUBLE : LEN_SINGLE;
                        err  <= 1'b0;
                        k    <= 7'd0;
                        j    <= 5'd0;
                        tmo  <= 16'd0;
                    end
                end
                ST_LOAD: begin
                    if (i_s_valid) begin
                        k <= k + 7'd1;
                    end
                end
                ST_START: begin
                    tmo <= 16'd1;
                end
                ST_ARM, ST_WAIT: begin
                    if (tmo_hit) begin
                        err <= 1'b1;
                    end else begin
                        tmo <= tmo_inc[15:0];
                    end
                end
                ST_RD: begin
                    d_data  <= i_core_data;
                    d_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (i_d_ready) begin
                        d_valid <= 1'b0;
                        j       <= j + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_d_data  = d_data;
    assign o_d_valid = d_valid;
    assign o_d_last  = (state == ST_OUT) && (j == 5'd31);
    assign o_busy    = (state != ST_IDLE);
    assign o_err     = err;

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// tb/tb_sha256_host_ctrl.sv - directed bench for sha256_host_ctrl with a behavioural sha256_core register model
module tb_sha256_host_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic       i_cmd_mode = 1'b0;
    logic       o_cmd_ready;
    logic [7:0] i_s_data = 8'h00;
    logic       i_s_valid = 1'b0;
    logic       o_s_ready;
    logic [6:0] o_core_addr;
    logic [7:0] o_core_data;
    logic       o_core_we;
    logic [7:0] core_rdata;
    logic       core_irq = 1'b1;
    logic [7:0] o_d_data;
    logic       o_d_valid;
    logic       i_d_ready = 1'b0;
    logic       o_d_last;
    logic       o_busy;
    logic       o_err;

    sha256_host_ctrl dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_mode  (i_cmd_mode),
        .o_cmd_ready (o_cmd_ready),
        .i_s_data    (i_s_data),
        .i_s_valid   (i_s_valid),
        .o_s_ready   (o_s_ready),
        .o_core_addr (o_core_addr),
        .o_core_data (o_core_data),
        .o_core_we   (o_core_we),
        .i_core_data (core_rdata),
        .i_core_irq  (core_irq),
        .o_d_data    (o_d_data),
        .o_d_valid   (o_d_valid),
        .i_d_ready   (i_d_ready),
        .o_d_last    (o_d_last),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [255:0] DG_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DG_GEN =
        256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000;
    localparam logic [639:0] GEN_HDR = {
        32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // core model state
    logic [7:0] mem [0:127];
    logic       st_mode = 1'b0;
    logic       start_d = 1'b0;
    int         busy_cnt = 0;
    int         lat = 20;
    bit         hang = 1'b0;
    int         wr_cnt = 0;
    int         st_cnt = 0;
    int         order_err = 0;
    int         proto_err = 0;
    int         exp_len = 64;
    logic [6:0] prev_addr = 7'd0;
    bit         have_prev = 1'b0;

    logic [7:0] msg [0:79];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Completion flag: drops one cycle after start is seen, rises after lat cycles.
    always @(posedge i_clk) begin
        if (o_core_we && o_core_addr == 7'h51 && o_core_data[0]) begin
            start_d <= 1'b1;
            st_mode <= o_core_data[1];
        end else begin
            start_d <= 1'b0;
        end
        if (start_d) begin
            core_irq <= 1'b0;
            busy_cnt <= lat;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1 && !hang) core_irq <= 1'b1;
        end
    end

    // Digest registers: address DIGEST_BASE+i holds the i-th least significant byte.
    logic [255:0] dsel;
    int           di;
    always_comb begin
        dsel = st_mode ? DG_GEN : DG_ABC;
        di   = int'(o_core_addr) - 'h58;
        if (di >= 0 && di < 32) core_rdata = dsel[di*8 +: 8];
        else                    core_rdata = 8'h00;
    end

    // Write monitor: message writes must descend from LEN-1, writes only in load/start.
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            if (i_cmd_valid && o_cmd_ready) begin
                wr_cnt    <= 0;
                st_cnt    <= 0;
                have_prev <= 1'b0;
            end else if (o_core_we) begin
                if (o_core_addr == 7'h51) begin
                    st_cnt <= st_cnt + 1;
                    if (o_s_ready) proto_err <= proto_err + 1;
                end else begin
                    mem[o_core_addr] <= o_core_data;
                    wr_cnt           <= wr_cnt + 1;
                    if (!o_s_ready) proto_err <= proto_err + 1;
                    if (have_prev ? (o_core_addr != prev_addr - 7'd1)
                                  : (o_core_addr != 7'(exp_len - 1)))
                        order_err <= order_err + 1;
                    prev_addr <= o_core_addr;
                    have_prev <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic build_msg(input bit mode);
        logic [639:0] hdr;
        hdr = GEN_HDR;
        for (int i = 0; i < 80; i++) msg[i] = 8'h00;
        if (mode) begin
            for (int i = 0; i < 80; i++) msg[i] = hdr[639 - 8*i -: 8];
        end else begin
            msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h80;
            msg[63] = 8'h18;
        end
    endtask

    task automatic issue_cmd(input bit mode);
        build_msg(mode);
        exp_len = mode ? 80 : 64;
        @(negedge i_clk);
        check("cmd_ready_idle", {31'd0, o_cmd_ready}, 32'd1);
        i_cmd_valid = 1'b1;
        i_cmd_mode  = mode;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic load_msg(input int len, input bit bp);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < len && guard < 1000) begin
            i_s_valid = bp ? ((guard % 2) == 0) : 1'b1;
            i_s_data  = msg[k];
            @(negedge i_clk);
            acc = i_s_valid && o_s_ready;
            @(posedge i_clk);
            #1;
            if (acc) k++;
            guard++;
        end
        i_s_valid = 1'b0;
        check("load_count", k, len);
    endtask

    task automatic run_cmd(input bit mode, input bit bp);
        logic [7:0]   got [0:31];
        logic [255:0] exp_dg;
        logic [7:0]   cap;
        int           len, guard, unstable, lastbad, membad;
        bit           timed_out;
        len       = mode ? 80 : 64;
        exp_dg    = mode ? DG_GEN : DG_ABC;
        unstable  = 0;
        lastbad   = 0;
        timed_out = 1'b0;
        for (int b = 0; b < 32; b++) got[b] = 8'h00;
        issue_cmd(mode);
        check("busy_after_cmd", {31'd0, o_busy}, 32'd1);
        load_msg(len, bp);
        check("s_ready_after_load", {31'd0, o_s_ready}, 32'd0);
        for (int b = 0; b < 32; b++) begin
            guard = 0;
            @(negedge i_clk);
            while (!o_d_valid && guard < 3000) begin
                @(negedge i_clk);
                guard++;
            end
            if (!o_d_valid) begin
                timed_out = 1'b1;
                break;
            end
            cap = o_d_data;
            if (bp) begin
                repeat (7) begin
                    @(negedge i_clk);
                    if (!o_d_valid || o_d_data != cap) unstable++;
                end
            end
            got[b] = cap;
            if (o_d_last != (b == 31)) lastbad++;
            i_d_ready = 1'b1;
            @(posedge i_clk);
            #1;
            i_d_ready = 1'b0;
        end
        check("digest_timeout", {31'd0, timed_out}, 32'd0);
        @(negedge i_clk);
        check("busy_after_last", {31'd0, o_busy}, 32'd0);
        check("dvalid_after_last", {31'd0, o_d_valid}, 32'd0);
        for (int w = 0; w < 8; w++)
            check($sformatf("digest_m%0d_w%0d", mode, w),
                  {got[4*w], got[4*w+1], got[4*w+2], got[4*w+3]},
                  exp_dg[255 - 32*w -: 32]);
        check("last_flag", lastbad, 0);
        check("hold_stable", unstable, 0);
        membad = 0;
        for (int i = 0; i < len; i++)
            if (mem[len - 1 - i] !== msg[i]) membad++;
        check("msg_mem", membad, 0);
        check("msg_writes", wr_cnt, len);
        check("status_writes", st_cnt, 1);
        check("status_mode", {31'd0, st_mode}, {31'd0, mode});
    endtask

    initial begin
        int c0, cerr, guard;
        bit saw_start, saw_dvalid;

        #12;
        @(negedge i_clk);
        check("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("rst_outs", {24'd0, o_busy, o_s_ready, o_core_we, o_d_valid, o_d_last, o_err, 2'b00}, 32'd0);
        check("rst_d_data", {24'd0, o_d_data}, 32'd0);
        i_rst_n = 1'b1;

        lat = 20; hang = 1'b0;
        run_cmd(1'b0, 1'b0);
        run_cmd(1'b1, 1'b0);
        run_cmd(1'b0, 1'b1);

        // completion never arrives
        hang = 1'b1;
        issue_cmd(1'b0);
        load_msg(64, 1'b0);
        saw_start = 1'b0;
        c0 = 0;
        guard = 0;
        while (!saw_start && guard < 10) begin
            @(negedge i_clk);
            if (o_core_we && o_core_addr == 7'h51) begin
                saw_start = 1'b1;
                c0 = cyc;
            end
            guard++;
        end
        check("tmo_start_seen", {31'd0, saw_start}, 32'd1);
        saw_dvalid = 1'b0;
        guard = 0;
        cerr = 0;
        while (!o_err && guard < 2000) begin
            @(negedge i_clk);
            if (o_d_valid) saw_dvalid = 1'b1;
            guard++;
        end
        cerr = cyc;
        check("tmo_err", {31'd0, o_err}, 32'd1);
        check("tmo_cycles", cerr - c0, 1024);
        check("tmo_idle", {30'd0, o_busy, o_cmd_ready}, 32'd1);
        check("tmo_no_digest", {31'd0, saw_dvalid}, 32'd0);
        hang = 1'b0;

        run_cmd(1'b0, 1'b0);
        check("err_cleared", {31'd0, o_err}, 32'd0);

        // reset while waiting for completion
        lat = 60;
        issue_cmd(1'b0);
        load_msg(64, 1'b0);
        repeat (10) @(negedge i_clk);
        check("mid_wait_busy", {31'd0, o_busy}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("async_rst_outs", {26'd0, o_busy, o_s_ready, o_core_we, o_d_valid, o_d_last, o_err}, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        lat = 20;
        run_cmd(1'b0, 1'b0);

        check("write_order", order_err, 0);
        check("write_protocol", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/sha256_host_ctrl.md
Name: sha256_host_ctrl

Overview:
- Bus initiator that drives the byte-wide register interface of sha256_core from a streaming side.
- Accepts a command and a message byte stream, then:
  - writes the message bytes into the core's message window;
  - starts a single or Bitcoin double hash;
  - waits for the core's completion interrupt;
  - reads the 32-byte digest back out as a ready/valid byte stream.
- Sits between a host DMA/UART stream and sha256_core.

Parameters:
- MSG_BASE, 7'h00, first message-byte address in the core.
- STATUS_ADDR, 7'h51, core status register address.
- DIGEST_BASE, 7'h58, lowest digest byte address (32 bytes, DIGEST_BASE..DIGEST_BASE+31).
- TIMEOUT_CYC, 16'd1024, maximum cycles to wait for completion.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, reset.
- i_cmd_valid, in, 1, command request.
- i_cmd_mode, in, 1, 0 = single hash of 64-byte padded block; 1 = Bitcoin double hash of 80-byte header.
- o_cmd_ready, out, 1, high only in IDLE.
- i_s_data, in, 8, message byte.
- i_s_valid, in, 1, message byte valid.
- o_s_ready, out, 1, message byte accepted.
- o_core_addr, out, 7, core register address.
- o_core_data, out, 8, core write data.
- o_core_we, out, 1, core write strobe.
- i_core_data, in, 8, core combinational read data.
- i_core_irq, in, 1, core completed flag.
- o_d_data, out, 8, digest byte.
- o_d_valid, out, 1, digest byte valid.
- i_d_ready, in, 1, digest sink ready.
- o_d_last, out, 1, marks the 32nd digest byte.
- o_busy, out, 1, high when not IDLE.
- o_err, out, 1, sticky timeout flag.

Behaviour:
- Reset: i_rst_n asynchronous, active-low; clock i_clk. All outputs 0 except o_cmd_ready=1. State IDLE, counters 0. Reset mid-operation aborts immediately; the core is not cleaned up.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid, latch mode, set LEN = 64 or 80, clear o_err, go to LOAD.
- LOAD:
  - o_s_ready=1; o_core_we = i_s_valid.
  - Byte index k (0 = first byte): o_core_addr = MSG_BASE + LEN-1-k, o_core_data = i_s_data.
  - k increments per accepted byte; one byte per cycle maximum; stalls are allowed.
  - After byte LEN-1 is accepted, go to START.
  - Extra stream bytes are not accepted (o_s_ready=0 outside LOAD).
- START:
  - One cycle: o_core_we=1, addr = STATUS_ADDR, data = {5'b0, 1'b0, mode, 1'b1}.
  - Bit0 is start, bit1 is Bitcoin mode, bit2 is nonce sweep and is always 0.
  - Go to ARM.
- ARM:
  - Wait for i_core_irq=0; the core clears it one cycle after it sees start. Then go to WAIT.
  - The timeout counter runs from START.
- WAIT: on i_core_irq=1, go to RD.
- Timeout:
  - Counter reaches TIMEOUT_CYC in ARM or WAIT: set o_err, go to IDLE.
  - No digest is output.
- RD:
  - o_core_addr = DIGEST_BASE + 31 - j (j = 0..31; MSB-first, big-endian SHA order).
  - Read data is sampled combinationally into the o_d_data register at the cycle edge.
  - Set o_d_valid, go to OUT.
- OUT:
  - Hold o_d_data/o_d_valid until i_d_ready.
  - o_d_last=1 when j=31.
  - On handshake: j++; go to RD, or to IDLE after j=31.
  - Throughput: one byte per 2 cycles.
- o_core_we is only ever high in LOAD and START. In RD/OUT o_core_addr is held stable. In IDLE o_core_addr = STATUS_ADDR.
- i_cmd_valid outside IDLE is ignored.
- All counters are fixed width: k 7b, j 5b, timeout 16b, saturating compare.

Decomposition:
- Shared package/defines header holds:
  - core address map: STATUS_ADDR, DIGEST_BASE/END, END_W_MEM_ADDR;
  - status bit indices: START, BITCOIN_MODE, NONCE_SWEEP, COMPLETED;
  - state encoding.
- No sub-module; a single FSM with a datapath counter.

Test Plan:
- Mode 0, "abc" padded block (61626380 00..00 00000018): digest stream ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. o_d_last is on byte 0xad; o_busy falls after it.
- Mode 1, Bitcoin genesis header (80 bytes, 0100000000...1dac2b7c): digest stream 6fe28c0a b6f1b372 c1a6a246 ae63f74f 931e8365 e15a089c 68d61900 00000000.
- Backpressure: i_s_valid toggling 50% and i_d_ready low for 7 cycles per byte: same "abc" digest; no duplicated or dropped bytes; o_d_data stable while o_d_valid && !i_d_ready.
- Timeout: core model holds i_core_irq=0 forever. o_err=1 exactly TIMEOUT_CYC cycles after START; return to IDLE; no o_d_valid.
- Reset asserted mid-WAIT: all outputs return to reset values asynchronously. A following mode-0 "abc" command completes correctly.
- Protocol check (assertion): no core write while in ARM/WAIT/RD/OUT. Exactly 64 or 80 message writes plus 1 status write per command, at descending addresses LEN-1..0.
